// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-word RAM port between the icache and the dcache.
//
// The dcache has priority. While the icache is waiting, the dcache can win at most
// MAX_D_STREAK grants in a row before the icache is served. A grant holds the RAM
// port until ram_ready arrives or the access times out. The owning wait output is
// low for exactly the completing cycle, and the load word is valid in that cycle.
// A timeout returns ERR_WORD on reads and sets a sticky error flag.
//
// Ports:
//   CLK, RST           clock; synchronous active-high reset
//   iREN, iaddr        icache read request and word address
//   iwait, iload       icache handshake (low on completion) and read data
//   dREN, dWEN         dcache read / write request (a write wins if both are set)
//   daddr, dstore      dcache word address and write data
//   dwait, dload       dcache handshake (low on completion) and read data
//   ram_REN, ram_WEN   RAM strobes, registered, held for the whole access
//   ram_addr/ram_store RAM address and write data, taken from the latched request
//   ram_load/ram_ready RAM read data and one-cycle completion pulse
//   err                sticky timeout flag, cleared only by RST

module mem_arbiter #(
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned TIMEOUT      = 64,
    parameter logic [31:0] ERR_WORD     = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        RST,
    // icache side
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    // dcache side
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    // RAM side
    output logic        ram_REN,
    output logic        ram_WEN,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_store,
    input  logic [31:0] ram_load,
    input  logic        ram_ready,
    // status
    output logic        err
);

    localparam int unsigned DW = 32;
    localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        I_ACC = 2'd1,
        D_ACC = 2'd2
    } state_e;

    state_e          state_q;
    logic            wr_q;           // latched op: 1 = write
    logic [SW-1:0]   d_streak_q;     // consecutive dcache grants while icache waits
    logic [TW-1:0]   tmo_q;          // cycles spent in the current access
    logic            err_q;
    logic            ram_ren_q;
    logic            ram_wen_q;
    logic [DW-1:0]   ram_addr_q;
    logic [DW-1:0]   ram_store_q;

    logic            dreq_c;
    logic            d_grant_c;
    logic            i_grant_c;
    logic            acc_c;
    logic            tmo_hit_c;
    logic            done_c;
    logic            tmo_expire_c;
    logic [DW-1:0]   load_c;
    logic [SW-1:0]   d_streak_inc_c;

    // Grant and completion decode
    always_comb begin
        dreq_c         = dREN | dWEN;
        d_grant_c      = dreq_c & (~iREN | (d_streak_q < SW'(MAX_D_STREAK)));
        i_grant_c      = ~d_grant_c & iREN;
        acc_c          = (state_q == I_ACC) || (state_q == D_ACC);
        tmo_hit_c      = (tmo_q == TW'(TIMEOUT - 1));
        done_c         = acc_c & (ram_ready | tmo_hit_c);
        // A ready pulse in the timeout cycle still counts as a normal completion.
        tmo_expire_c   = acc_c & tmo_hit_c & ~ram_ready;
        d_streak_inc_c = (d_streak_q == SW'(MAX_D_STREAK)) ? d_streak_q
                                                            : d_streak_q + SW'(1);
        if (wr_q) begin
            load_c = '0;
        end else if (ram_ready) begin
            load_c = ram_load;
        end else begin
            load_c = ERR_WORD;
        end
    end

    // Wait/load handshake: combinational so the wait pulse lands in the ready cycle
    always_comb begin
        iwait = 1'b1;
        iload = '0;
        dwait = 1'b1;
        dload = '0;
        if (done_c && (state_q == I_ACC)) begin
            iwait = 1'b0;
            iload = load_c;
        end
        if (done_c && (state_q == D_ACC)) begin
            dwait = 1'b0;
            dload = load_c;
        end
    end

    // Arbiter state machine with registered RAM-side outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            d_streak_q  <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            ram_ren_q   <= 1'b0;
            ram_wen_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_store_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    tmo_q <= '0;
                    if (d_grant_c) begin
                        state_q     <= D_ACC;
                        wr_q        <= dWEN;
                        ram_ren_q   <= ~dWEN;
                        ram_wen_q   <= dWEN;
                        ram_addr_q  <= daddr;
                        ram_store_q <= dWEN ? dstore : '0;
                        d_streak_q  <= iREN ? d_streak_inc_c : '0;
                    end else if (i_grant_c) begin
                        state_q     <= I_ACC;
                        wr_q        <= 1'b0;
                        ram_ren_q   <= 1'b1;
                        ram_wen_q   <= 1'b0;
                        ram_addr_q  <= iaddr;
                        ram_store_q <= '0;
                        d_streak_q  <= '0;
                    end
                end

                I_ACC, D_ACC: begin
                    if (done_c) begin
                        state_q     <= IDLE;
                        tmo_q       <= '0;
                        ram_ren_q   <= 1'b0;
                        ram_wen_q   <= 1'b0;
                        ram_addr_q  <= '0;
                        ram_store_q <= '0;
                        if (tmo_expire_c) begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end

                default: begin
                    state_q   <= IDLE;
                    tmo_q     <= '0;
                    ram_ren_q <= 1'b0;
                    ram_wen_q <= 1'b0;
                end
            endcase
        end
    end

    assign ram_REN   = ram_ren_q;
    assign ram_WEN   = ram_wen_q;
    assign ram_addr  = ram_addr_q;
    assign ram_store = ram_store_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, icache read, priority, streak guard,
// write, timeout with sticky error, and reset mid-access.

module tb_mem_arbiter;

    logic        CLK;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ram_REN;
    logic        ram_WEN;
    logic [31:0] ram_addr;
    logic [31:0] ram_store;
    logic [31:0] ram_load;
    logic        ram_ready;
    logic        err;

    int vectors = 0;
    int errors  = 0;

    mem_arbiter dut (
        .CLK       (CLK),
        .RST       (RST),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .iwait     (iwait),
        .iload     (iload),
        .dREN      (dREN),
        .dWEN      (dWEN),
        .daddr     (daddr),
        .dstore    (dstore),
        .dwait     (dwait),
        .dload     (dload),
        .ram_REN   (ram_REN),
        .ram_WEN   (ram_WEN),
        .ram_addr  (ram_addr),
        .ram_store (ram_store),
        .ram_load  (ram_load),
        .ram_ready (ram_ready),
        .err       (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Move to 2 time units after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        bit is_i;
        bit early;

        RST       = 1'b1;
        iREN      = 1'b0;
        iaddr     = '0;
        dREN      = 1'b0;
        dWEN      = 1'b0;
        daddr     = '0;
        dstore    = '0;
        ram_load  = '0;
        ram_ready = 1'b0;

        // Reset values
        tick();
        tick();
        #1;
        chk1 ("rst_iwait",     iwait,     1'b1);
        chk1 ("rst_dwait",     dwait,     1'b1);
        chk32("rst_iload",     iload,     32'h0);
        chk32("rst_dload",     dload,     32'h0);
        chk1 ("rst_ram_REN",   ram_REN,   1'b0);
        chk1 ("rst_ram_WEN",   ram_WEN,   1'b0);
        chk32("rst_ram_addr",  ram_addr,  32'h0);
        chk32("rst_ram_store", ram_store, 32'h0);
        chk1 ("rst_err",       err,       1'b0);
        RST = 1'b0;

        // 1: icache read, ready in the third access cycle
        iREN  = 1'b1;
        iaddr = 32'h0000_0040;
        #1;
        chk1("t1_idle_ren", ram_REN, 1'b0);
        chk1("t1_idle_iwait", iwait, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 3) begin
                ram_ready = 1'b1;
                ram_load  = 32'h2402_0001;
            end
            #1;
            chk1 ("t1_ram_REN",  ram_REN,  1'b1);
            chk32("t1_ram_addr", ram_addr, 32'h0000_0040);
            chk1 ("t1_dwait",    dwait,    1'b1);
            chk1 ("t1_iwait",    iwait,    (c == 3) ? 1'b0 : 1'b1);
        end
        chk32("t1_iload", iload, 32'h2402_0001);
        chk32("t1_dload", dload, 32'h0);
        tick();
        ram_ready = 1'b0;
        ram_load  = '0;
        iREN      = 1'b0;
        #1;
        chk1 ("t1_after_ren",   ram_REN, 1'b0);
        chk1 ("t1_after_iwait", iwait,   1'b1);
        chk32("t1_after_iload", iload,   32'h0);

        // 2: simultaneous requests, dcache first then icache
        iREN  = 1'b1;
        iaddr = 32'h0000_0080;
        dREN  = 1'b1;
        daddr = 32'h0000_0200;
        tick();
        ram_ready = 1'b1;
        ram_load  = 32'h1111_1111;
        #1;
        chk32("t2_d_addr",  ram_addr, 32'h0000_0200);
        chk1 ("t2_d_REN",   ram_REN,  1'b1);
        chk1 ("t2_d_WEN",   ram_WEN,  1'b0);
        chk1 ("t2_dwait",   dwait,    1'b0);
        chk32("t2_dload",   dload,    32'h1111_1111);
        chk1 ("t2_iwait_d", iwait,    1'b1);
        tick();
        ram_ready = 1'b0;
        ram_load  = '0;
        dREN      = 1'b0;
        #1;
        chk1("t2_gap_ren", ram_REN, 1'b0);
        tick();
        ram_ready = 1'b1;
        ram_load  = 32'h2222_2222;
        #1;
        chk32("t2_i_addr", ram_addr, 32'h0000_0080);
        chk1 ("t2_iwait",  iwait,    1'b0);
        chk32("t2_iload",  iload,    32'h2222_2222);
        chk1 ("t2_dwait_i", dwait,   1'b1);
        tick();
        ram_ready = 1'b0;
        ram_load  = '0;
        iREN      = 1'b0;

        // 3: dcache held with icache pending -> D D D D I, twice
        iREN  = 1'b1;
        iaddr = 32'h0000_00C0;
        dREN  = 1'b1;
        dWEN  = 1'b0;
        daddr = 32'h0000_0300;
        for (int k = 0; k < 10; k++) begin
            is_i = ((k % 5) == 4);
            tick();
            ram_ready = 1'b1;
            ram_load  = 32'hA000_0000 + 32'(k);
            #1;
            chk32("t3_addr",  ram_addr, is_i ? 32'h0000_00C0 : 32'h0000_0300);
            chk1 ("t3_iwait", iwait,    ~is_i);
            chk1 ("t3_dwait", dwait,    is_i);
            tick();
            ram_ready = 1'b0;
            ram_load  = '0;
        end
        iREN = 1'b0;
        dREN = 1'b0;

        // 4: write wins over read; dload stays 0 on a write
        dREN   = 1'b1;
        dWEN   = 1'b1;
        daddr  = 32'h0000_0100;
        dstore = 32'hDEAD_BEEF;
        tick();
        ram_ready = 1'b1;
        ram_load  = 32'h1234_5678;
        #1;
        chk1 ("t4_WEN",   ram_WEN,   1'b1);
        chk1 ("t4_REN",   ram_REN,   1'b0);
        chk32("t4_addr",  ram_addr,  32'h0000_0100);
        chk32("t4_store", ram_store, 32'hDEAD_BEEF);
        chk1 ("t4_dwait", dwait,     1'b0);
        chk32("t4_dload", dload,     32'h0);
        tick();
        ram_ready = 1'b0;
        ram_load  = '0;
        dREN      = 1'b0;
        dWEN      = 1'b0;
        dstore    = '0;

        // 5: read with no ready completes in access cycle 64 with ERR_WORD
        dREN  = 1'b1;
        daddr = 32'h0000_0180;
        tick();
        early = 1'b0;
        for (int c = 1; c < 64; c++) begin
            #1;
            if (dwait !== 1'b1) early = 1'b1;
            tick();
        end
        chk1("t5_no_early", early, 1'b0);
        #1;
        chk1 ("t5_dwait",     dwait, 1'b0);
        chk32("t5_dload",     dload, 32'hBAD1_BAD1);
        chk1 ("t5_err_before", err,  1'b0);
        tick();
        dREN = 1'b0;
        #1;
        chk1("t5_err_set",  err,     1'b1);
        chk1("t5_idle_ren", ram_REN, 1'b0);
        iREN  = 1'b1;
        iaddr = 32'h0000_0044;
        tick();
        ram_ready = 1'b1;
        ram_load  = 32'h5555_AAAA;
        #1;
        chk1 ("t5_iwait",    iwait, 1'b0);
        chk32("t5_iload",    iload, 32'h5555_AAAA);
        chk1 ("t5_err_held", err,   1'b1);
        tick();
        ram_ready = 1'b0;
        ram_load  = '0;
        iREN      = 1'b0;

        // 6: reset during a dcache access; late ready is ignored
        dREN  = 1'b1;
        daddr = 32'h0000_01C0;
        tick();
        #1;
        chk1("t6_acc_ren", ram_REN, 1'b1);
        tick();
        RST  = 1'b1;
        dREN = 1'b0;
        #1;
        chk1("t6_rst_cycle_dwait", dwait, 1'b1);
        tick();
        RST       = 1'b0;
        ram_ready = 1'b1;
        ram_load  = 32'h7777_7777;
        #1;
        chk1 ("t6_ren",   ram_REN,  1'b0);
        chk32("t6_addr",  ram_addr, 32'h0);
        chk1 ("t6_err",   err,      1'b0);
        chk1 ("t6_dwait", dwait,    1'b1);
        chk1 ("t6_iwait", iwait,    1'b1);
        chk32("t6_dload", dload,    32'h0);
        tick();
        ram_ready = 1'b0;
        ram_load  = '0;
        #1;
        chk1("t6_still_idle", ram_REN, 1'b0);
        chk1("t6_dwait_idle", dwait,   1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the instruction cache and the data cache. Serves their single-word miss/write requests over one shared RAM port.
- Arbitrates between the two requesters, with data-side priority and a starvation guard for the instruction side.
- Holds each grant until the RAM completes the access, then returns the load word with a one-cycle wait-low handshake.
- Bounds every access with a timeout and records a sticky error when one fires.

Parameters:
- MAX_D_STREAK, 4: maximum consecutive dcache grants while iREN is pending before icache is forced.
- TIMEOUT, 64: cycles in an ACC state without ram_ready before the access is force-completed.
- ERR_WORD, 32'hBAD1BAD1: load value returned on a timed-out read.

Ports:
- CLK  in  1  clock
- RST  in  1  reset; synchronous, active-high
- iREN  in  1  icache read request
- iaddr  in  32  icache word address
- iwait  out  1  low for exactly the completing cycle of an icache access
- iload  out  32  icache read data; valid when iwait is low
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  32  dcache word address
- dstore  in  32  dcache write data
- dwait  out  1  low for exactly the completing cycle of a dcache access
- dload  out  32  dcache read data; valid when dwait is low
- ram_REN  out  1  RAM read strobe
- ram_WEN  out  1  RAM write strobe
- ram_addr  out  32  RAM address
- ram_store  out  32  RAM write data
- ram_load  in  32  RAM read data; valid with ram_ready
- ram_ready  in  1  one-cycle pulse when the RAM access is done
- err  out  1  sticky timeout flag

Behaviour:
- State machine: IDLE, I_ACC, D_ACC. State, latched request (addr, store, op), d_streak and tmo_cnt are all registered.
- Reset (RST high at a CLK edge), required values after that edge:
  - state=IDLE, d_streak=0, tmo_cnt=0, err=0.
  - iwait=1, dwait=1, iload=0, dload=0.
  - ram_REN=0, ram_WEN=0, ram_addr=0, ram_store=0.
- Reset mid-access: the access is abandoned. No wait-low pulse is issued for it.
- IDLE grant rules:
  - dreq = dREN | dWEN.
  - If dreq and (!iREN or d_streak < MAX_D_STREAK): go to D_ACC. Latch daddr and dstore. Op = write if dWEN, else read; dWEN wins if both dREN and dWEN are high.
  - Else if iREN: go to I_ACC and latch iaddr.
  - Else stay in IDLE.
  - Grant decision is made in IDLE; RAM strobes are asserted from the next cycle.
- d_streak update:
  - On a D grant with iREN high: d_streak increments, saturating at MAX_D_STREAK.
  - On a D grant with iREN low: d_streak clears.
  - On an I grant: d_streak clears.
- ACC states:
  - ram_REN or ram_WEN (per latched op), ram_addr and ram_store are driven from the latched request. ram_store=0 for reads.
  - In I_ACC, ram_REN=1 and ram_WEN=0.
  - tmo_cnt increments every ACC cycle and clears when entering IDLE.
- Completion:
  - Triggered in the cycle ram_ready=1, or the cycle tmo_cnt == TIMEOUT-1.
  - The owning wait output goes low for that single cycle (combinational from ram_ready). The owning load output is ram_load, or ERR_WORD on timeout (0 for writes).
  - Next state is IDLE.
  - Timeout sets err, which stays set until RST.
- Non-completing cycles: both wait outputs are 1 and both load outputs are 0. The non-owning requester always sees wait=1.
- Minimum latency: request seen in IDLE at cycle 0, ACC at cycle 1; if ram_ready arrives in cycle 1, wait is low in cycle 1. Back-to-back accesses therefore take at least 2 cycles each.
- Requesters hold their request and address until they see wait low.
- Request dropped mid-access (e.g. a cache clearing on halt): the arbiter still completes the RAM transaction and the wait pulse is still generated; the requester ignores it.
- ram_ready in IDLE is ignored.
- Address/data changes during ACC have no effect, because the latched copies are used.

Test Plan:
1. iREN=1, iaddr=32'h0000_0040, ram_ready returns 3 cycles after the grant with ram_load=32'h2402_0001 -> ram_REN=1 and ram_addr=32'h40 for 3 cycles; iwait low for 1 cycle with iload=32'h2402_0001; dwait stays 1 throughout.
2. iREN and dREN high in the same cycle, d_streak=0 -> D_ACC granted first; I_ACC follows immediately after dcache completes; ram_addr switches from daddr to iaddr.
3. dREN held continuously while iREN is pending, MAX_D_STREAK=4 -> exactly 4 dcache grants, then an icache grant; d_streak reads 0 after the I grant.
4. dWEN=1 and dREN=1, daddr=32'h100, dstore=32'hDEAD_BEEF -> ram_WEN=1, ram_REN=0, ram_store=32'hDEAD_BEEF; dload=0 on completion.
5. Read access with no ram_ready, TIMEOUT=64 -> completion in ACC cycle 64; dload=32'hBAD1BAD1; err=1, and err remains 1 through later normal accesses until RST.
6. RST asserted during D_ACC -> after the next edge: state=IDLE, ram_REN=0, dwait=1, err=0; a late ram_ready is ignored.
